psel_rr: RTL and testbench

Parametrised round-robin priority selector with registered, held grants. Generalises the fixed-priority ps2/ps4/ps8 selector tree to NUM_REQ requesters. It adds:
- a rotating priority pointer for fairness;
- grant ownership held across cycles while the owner keeps requesting;
- a bounded hold time so one requester cannot starve the others.

It sits in front of any shared resource (bus port, functional unit, CDB slot) that needs a single grant per cycle.

---
 rtl/psel_rr_pkg.sv | 15 +
 rtl/psel_rr_pick.sv | 43 ++++
 rtl/psel_rr.sv | 142 ++++++++++++++
 tb/tb_psel_rr.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psel_rr_pkg.sv
// psel_pkg: shared definitions for the psel_rr round-robin selector.
//   state_t      - arbiter state (IDLE: no owner, OWN: owner held in gnt_idx)
//   NUM_REQ_DEF  - default requester count
//   MAX_HOLD_DEF - default hold limit (used only with PSEL_RR_HOLD_LIMIT_EN)
package psel_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   localparam int unsigned NUM_REQ_DEF  = 8;
   localparam int unsigned MAX_HOLD_DEF = 4;

endpackage

// File: rtl/psel_rr_pick.sv
// psel_rr_pick: combinational rotating-priority picker.
// The search order is ptr, ptr-1, ..., 0, NUM_REQ-1, ..., ptr+1. The first
// request that is set and not masked by excl wins.
// Ports:
//   req       in  NUM_REQ  request vector
//   ptr       in  IDX_W    highest-priority index for this search
//   excl      in  NUM_REQ  requesters removed from the search
//   win       out NUM_REQ  one-hot winner (zero when none)
//   win_idx   out IDX_W    binary winner index (zero when none)
//   win_valid out 1        a winner exists
module psel_rr_pick #(
   parameter  int unsigned NUM_REQ = psel_pkg::NUM_REQ_DEF,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic [NUM_REQ-1:0] excl,
   output logic [NUM_REQ-1:0] win,
   output logic [IDX_W-1:0]   win_idx,
   output logic               win_valid
);

   logic [NUM_REQ-1:0] elig;
   logic [IDX_W-1:0]   cand;

   always_comb begin
      elig      = req & ~excl;
      win       = '0;
      win_idx   = '0;
      win_valid = 1'b0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         // Step i positions downward from ptr, wrapping modulo NUM_REQ.
         cand = IDX_W'((32'(ptr) + NUM_REQ - i) % NUM_REQ);
         if (!win_valid && elig[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
            win[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/psel_rr.sv
// psel_rr: round-robin priority selector with registered, held grants.
// Optional feature macro: PSEL_RR_HOLD_LIMIT_EN enables the bounded hold
// (hold_cnt + forced rotation); undefined, an owner keeps the grant while it
// keeps requesting and en stays high, and MAX_HOLD is ignored.
// Ports:
//   clock     in  1        rising-edge clock
//   reset     in  1        synchronous active-high reset
//   en        in  1        arbitration enable; low drops any grant
//   req       in  NUM_REQ  request vector
//   gnt       out NUM_REQ  registered one-hot grant
//   gnt_idx   out IDX_W    registered owner index (0 when no owner)
//   gnt_valid out 1        registered, high exactly when gnt != 0
//   req_up    out 1        combinational en & |req
module psel_rr
   import psel_pkg::*;
#(
   parameter  int unsigned NUM_REQ  = NUM_REQ_DEF,
   parameter  int unsigned MAX_HOLD = MAX_HOLD_DEF,
   localparam int unsigned IDX_W    = $clog2(NUM_REQ)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic               req_up
);

   localparam logic [IDX_W-1:0] PTR_TOP = IDX_W'(NUM_REQ - 1);

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic               own_req;
   logic               rotate;
   logic               handover;
   logic [IDX_W-1:0]   rot_ptr;
   logic [IDX_W-1:0]   pick_ptr;
   logic [NUM_REQ-1:0] pick_excl;
   logic [NUM_REQ-1:0] pick_win;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;

`ifdef PSEL_RR_HOLD_LIMIT_EN
   localparam int unsigned    HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
   logic [HW-1:0] hold_cnt;
   logic          others;

   assign others = |(req & ~gnt);
   assign rotate = (state == OWN) && own_req && (hold_cnt == HOLD_LAST) && others;
`else
   logic unused_max_hold;

   assign unused_max_hold = (MAX_HOLD == 0);
   assign rotate          = 1'b0;
`endif

   assign req_up  = en & (|req);
   assign own_req = |(req & gnt);
   assign rot_ptr = (gnt_idx == '0) ? PTR_TOP : gnt_idx - 1'b1;

   // On a release or forced rotation the search already uses the advanced
   // pointer with the outgoing owner masked, so handover needs no idle cycle.
   assign handover  = (state == OWN) && (!own_req || rotate);
   assign pick_ptr  = handover ? rot_ptr : ptr;
   assign pick_excl = handover ? gnt : '0;

   psel_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req       (req),
      .ptr       (pick_ptr),
      .excl      (pick_excl),
      .win       (pick_win),
      .win_idx   (pick_idx),
      .win_valid (pick_valid)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= PTR_TOP;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
`ifdef PSEL_RR_HOLD_LIMIT_EN
         hold_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (en && pick_valid) begin
                  gnt       <= pick_win;
                  gnt_idx   <= pick_idx;
                  gnt_valid <= 1'b1;
                  state     <= OWN;
`ifdef PSEL_RR_HOLD_LIMIT_EN
                  hold_cnt  <= '0;
`endif
               end
            end
            OWN: begin
               // A release advances ptr even when en low drops the grant.
               if (!own_req) begin
                  ptr <= rot_ptr;
               end
               if (!en) begin
                  gnt       <= '0;
                  gnt_idx   <= '0;
                  gnt_valid <= 1'b0;
                  state     <= IDLE;
               end else if (handover) begin
                  ptr <= rot_ptr;
                  if (pick_valid) begin
                     gnt       <= pick_win;
                     gnt_idx   <= pick_idx;
                     gnt_valid <= 1'b1;
`ifdef PSEL_RR_HOLD_LIMIT_EN
                     hold_cnt  <= '0;
`endif
                  end else begin
                     gnt       <= '0;
                     gnt_idx   <= '0;
                     gnt_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end else begin
`ifdef PSEL_RR_HOLD_LIMIT_EN
                  if (hold_cnt != HOLD_LAST) begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psel_rr.sv
module tb_psel_rr;

   localparam int N  = 8;
   localparam int MH = 4;
`ifdef PSEL_RR_HOLD_LIMIT_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         en    = 1'b0;
   logic [N-1:0] req   = '0;
   logic [N-1:0] gnt;
   logic [2:0]   gnt_idx;
   logic         gnt_valid;
   logic         req_up;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: owner (-1 = none), pointer, cycles the owner has been visible.
   int m_owner = -1;
   int m_ptr   = N - 1;
   int m_held  = 0;

   psel_rr #(
      .NUM_REQ  (N),
      .MAX_HOLD (MH)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .en        (en),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .req_up    (req_up)
   );

   always #5 clock = ~clock;

   function automatic int find_winner(input logic [N-1:0] r, input int p, input int ex);
      int res;
      res = -1;
      for (int j = 0; j < N; j++) begin
         int c;
         c = (p - j + N) % N;
         if (res < 0 && c != ex && r[c]) res = c;
      end
      return res;
   endfunction

   task automatic model_next(input logic rst, input logic e, input logic [N-1:0] r);
      int           k;
      int           w;
      bit           rel;
      bit           forced;
      logic [N-1:0] rest;
      if (rst) begin
         m_owner = -1;
         m_ptr   = N - 1;
         m_held  = 0;
      end else if (m_owner < 0) begin
         if (e) begin
            w = find_winner(r, m_ptr, -1);
            if (w >= 0) begin
               m_owner = w;
               m_held  = 1;
            end
         end
      end else begin
         k       = m_owner;
         rel     = !r[k];
         rest    = r;
         rest[k] = 1'b0;
         forced  = HOLD_EN && (m_held >= MH) && (rest != '0);
         if (rel) m_ptr = (k + N - 1) % N;
         if (!e) begin
            m_owner = -1;
            m_held  = 0;
         end else if (rel || forced) begin
            m_ptr   = (k + N - 1) % N;
            w       = find_winner(r, m_ptr, k);
            m_owner = w;
            m_held  = (w >= 0) ? 1 : 0;
         end else begin
            m_held++;
         end
      end
   endtask

   function automatic logic [N-1:0] exp_gnt();
      logic [N-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   function automatic logic [2:0] exp_idx();
      return (m_owner >= 0) ? 3'(m_owner) : 3'd0;
   endfunction

   task automatic cycle();
      model_next(reset, en, req);
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b1; req = 8'hFF;
      cycle();
      cycle();
      n_total++;
      if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0)
         $display("FAIL reset_outputs: got gnt=%b idx=%0d valid=%b want 0/0/0", gnt, gnt_idx, gnt_valid);
      else n_pass++;
      n_total++;
      if (dut.ptr !== 3'd7) $display("FAIL reset_ptr: got %0d want 7", dut.ptr);
      else n_pass++;
      reset = 1'b0; req = '0;
      cycle();
   endtask

   task automatic test_first_grant();
      en = 1'b1; req = 8'b0010_0110;
      cycle();
      n_total++;
      if (gnt !== 8'b0010_0000 || gnt_idx !== 3'd5 || gnt_valid !== 1'b1)
         $display("FAIL first_grant: got gnt=%b idx=%0d valid=%b want 00100000/5/1", gnt, gnt_idx, gnt_valid);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      req = 8'b0000_0110;
      cycle();
      n_total++;
      if (gnt !== 8'b0000_0100 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1)
         $display("FAIL handover: got gnt=%b idx=%0d valid=%b want 00000100/2/1", gnt, gnt_idx, gnt_valid);
      else n_pass++;
      n_total++;
      if (dut.ptr !== 3'd4) $display("FAIL handover_ptr: got %0d want 4", dut.ptr);
      else n_pass++;
   endtask

   task automatic test_hold_limit();
      int seq_w[12];
      int seq_h[12];
      seq_w = '{7, 7, 7, 7, 0, 0, 0, 0, 7, 7, 7, 7};
      seq_h = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
      reset = 1'b1; cycle(); reset = 1'b0;
      en = 1'b1; req = 8'h81;
      for (int i = 0; i < 12; i++) begin
         int want;
         cycle();
         want = HOLD_EN ? seq_w[i] : seq_h[i];
         n_total++;
         if (gnt_idx !== 3'(want) || gnt_valid !== 1'b1)
            $display("FAIL hold_seq[%0d]: got idx=%0d valid=%b want %0d/1", i, gnt_idx, gnt_valid, want);
         else n_pass++;
      end
   endtask

   task automatic test_en_req_up();
      reset = 1'b1; cycle(); reset = 1'b0;
      en = 1'b0; req = 8'hFF;
      #1;
      n_total++;
      if (req_up !== 1'b0) $display("FAIL req_up_en_low: got %b want 0", req_up);
      else n_pass++;
      cycle();
      n_total++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0)
         $display("FAIL en_low_no_grant: got gnt=%b valid=%b want 0/0", gnt, gnt_valid);
      else n_pass++;
      en = 1'b1; req = 8'b0000_1000;
      #1;
      n_total++;
      if (req_up !== 1'b1) $display("FAIL req_up_en_high: got %b want 1", req_up);
      else n_pass++;
      cycle();
      n_total++;
      if (gnt_idx !== 3'd3 || gnt_valid !== 1'b1)
         $display("FAIL own3: got idx=%0d valid=%b want 3/1", gnt_idx, gnt_valid);
      else n_pass++;
      en = 1'b0;
      cycle();
      n_total++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || dut.ptr !== 3'd7)
         $display("FAIL drop_en: got gnt=%b valid=%b ptr=%0d want 0/0/7", gnt, gnt_valid, dut.ptr);
      else n_pass++;
   endtask

   task automatic test_release_en_low();
      reset = 1'b1; cycle(); reset = 1'b0;
      en = 1'b1; req = 8'b0001_0000;
      cycle();
      en = 1'b0; req = 8'h00;
      cycle();
      n_total++;
      if (gnt !== 8'h00 || dut.ptr !== 3'd3)
         $display("FAIL release_en_low: got gnt=%b ptr=%0d want 0/3", gnt, dut.ptr);
      else n_pass++;
   endtask

   task automatic test_wrap_reset();
      reset = 1'b1; cycle(); reset = 1'b0;
      en = 1'b1; req = 8'h01;
      cycle();
      req = 8'h80;
      cycle();
      n_total++;
      if (gnt_idx !== 3'd7 || gnt_valid !== 1'b1 || dut.ptr !== 3'd7)
         $display("FAIL wrap: got idx=%0d valid=%b ptr=%0d want 7/1/7", gnt_idx, gnt_valid, dut.ptr);
      else n_pass++;
      reset = 1'b1;
      cycle();
      n_total++;
      if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || dut.ptr !== 3'd7)
         $display("FAIL reset_mid_grant: got gnt=%b idx=%0d valid=%b ptr=%0d want 0/0/0/7",
                  gnt, gnt_idx, gnt_valid, dut.ptr);
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) < 3) req = N'($urandom);
         else if ($urandom_range(0, 9) < 2) req[$urandom_range(0, N - 1)] = 1'b0;
         en    = ($urandom_range(0, 11) != 0);
         reset = ($urandom_range(0, 79) == 0);
         cycle();
         n_total++;
         if (gnt !== exp_gnt() || gnt_idx !== exp_idx() || gnt_valid !== (m_owner >= 0)) begin
            if (errs < 10)
               $display("FAIL rand_grant[%0d]: got gnt=%b idx=%0d valid=%b want %b/%0d/%b",
                        i, gnt, gnt_idx, gnt_valid, exp_gnt(), exp_idx(), (m_owner >= 0));
            errs++;
         end else n_pass++;
         n_total++;
         if (dut.ptr !== 3'(m_ptr)) begin
            if (errs < 10) $display("FAIL rand_ptr[%0d]: got %0d want %0d", i, dut.ptr, m_ptr);
            errs++;
         end else n_pass++;
         n_total++;
         if (req_up !== (en & (|req))) begin
            if (errs < 10) $display("FAIL rand_req_up[%0d]: got %b want %b", i, req_up, en & (|req));
            errs++;
         end else n_pass++;
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_grant();
      test_back_to_back();
      test_hold_limit();
      test_en_req_up();
      test_release_en_low();
      test_wrap_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
